// File: rtl/context_commit_pkg.sv
// Shared reference-CPU definitions: architectural context, CPU state encoding,
// commit-stage FSM states and trap causes.
package context_commit_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC    = 4'd2,
    S_MEM     = 4'd3,
    S_WB      = 4'd4,
    S_UNKNOWN = 4'hF
  } cpu_state_t;

  typedef struct packed {
    cpu_state_t  state;
    logic [31:0] pc;
    logic [31:0] data;
  } context_t;

  localparam int CTX_W = $bits(context_t);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DBG_HALT = 2'd1,
    TRAPPED  = 2'd2
  } commit_fsm_t;

  typedef enum logic [1:0] {
    TC_NONE    = 2'd0,
    TC_UNKNOWN = 2'd1,
    TC_WDT     = 2'd2
  } trap_cause_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc0_0000;

endpackage

// File: rtl/context_commit_watchdog.sv
// Dwell counter: counts consecutive same-state commits and pulses fire_o on the
// commit that would reach WDT_LIMIT. WDT_LIMIT of 0 disables firing.
module context_commit_watchdog #(
  parameter int WDT_LIMIT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic commit_i,
  input  logic same_state_i,
  input  logic clear_i,
  output logic fire_o
);

  localparam int DW = (WDT_LIMIT > 1) ? $clog2(WDT_LIMIT) : 1;
  localparam logic [DW-1:0] LIM_M1 = (WDT_LIMIT > 0) ? DW'(WDT_LIMIT - 1) : '0;

  logic [DW-1:0] dwell_q, dwell_d;

  assign fire_o = (WDT_LIMIT > 0) && commit_i && same_state_i && (dwell_q == LIM_M1);

  always_comb begin
    dwell_d = dwell_q;
    if (clear_i) begin
      dwell_d = '0;
    end else if (commit_i) begin
      if (!same_state_i || fire_o) dwell_d = '0;
      else                         dwell_d = dwell_q + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) dwell_q <= '0;
    else       dwell_q <= dwell_d;
  end

endmodule

// File: rtl/context_commit.sv
// Architectural context register: commits next_ctx each cycle while running,
// traps on S_UNKNOWN or watchdog expiry, counts retirements, supports debug halt.
module context_commit
  import context_commit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          WDT_LIMIT = 1024,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CTX_W-1:0] next_ctx,
  output logic [CTX_W-1:0] ctx,
  input  logic             halt_req,
  output logic             halted,
  input  logic             resume,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [31:0]      trap_pc,
  output logic [CNT_W-1:0] retired
);

  context_t    nx;
  context_t    ctx_q, ctx_d;
  commit_fsm_t fsm_q, fsm_d;
  logic        trap_q, trap_d;
  trap_cause_t cause_q, cause_d;
  logic [31:0] tpc_q, tpc_d;
  logic [CNT_W-1:0] ret_q, ret_d;

  logic commit, same_state, unk_hit, wdt_fire, clear_trap;

  assign nx         = context_t'(next_ctx);
  assign commit     = (fsm_q == RUN);
  assign same_state = (nx.state == ctx_q.state);
  assign unk_hit    = commit && (nx.state == S_UNKNOWN);
  assign clear_trap = (fsm_q == TRAPPED) && resume;

  context_commit_watchdog #(
    .WDT_LIMIT(WDT_LIMIT)
  ) u_wdt (
    .clk         (clk),
    .reset       (reset),
    .commit_i    (commit),
    .same_state_i(same_state),
    .clear_i     (clear_trap),
    .fire_o      (wdt_fire)
  );

  always_comb begin
    fsm_d   = fsm_q;
    ctx_d   = ctx_q;
    trap_d  = trap_q;
    cause_d = cause_q;
    tpc_d   = tpc_q;
    ret_d   = ret_q;
    case (fsm_q)
      RUN: begin
        // A watchdog fire discards next_ctx unless S_UNKNOWN is also being entered.
        if (wdt_fire && !unk_hit) begin
          ctx_d.state = S_UNKNOWN;
        end else begin
          ctx_d = nx;
          if (ctx_q.state != S_FETCH && ctx_q.state != S_UNKNOWN && nx.state == S_FETCH)
            ret_d = ret_q + CNT_W'(1);
        end
        if (unk_hit || wdt_fire) begin
          fsm_d   = TRAPPED;
          trap_d  = 1'b1;
          cause_d = unk_hit ? TC_UNKNOWN : TC_WDT;
          tpc_d   = ctx_q.pc;
        end else if (halt_req) begin
          fsm_d = DBG_HALT;
        end
      end
      DBG_HALT: begin
        if (resume) fsm_d = RUN;
      end
      TRAPPED: begin
        if (resume) begin
          fsm_d       = RUN;
          trap_d      = 1'b0;
          cause_d     = TC_NONE;
          ctx_d.state = S_FETCH;
          ctx_d.pc    = RESET_PC;
        end
      end
      default: fsm_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q      <= RUN;
      ctx_q      <= '0;
      ctx_q.state <= S_FETCH;
      ctx_q.pc   <= RESET_PC;
      trap_q     <= 1'b0;
      cause_q    <= TC_NONE;
      tpc_q      <= '0;
      ret_q      <= '0;
    end else begin
      fsm_q   <= fsm_d;
      ctx_q   <= ctx_d;
      trap_q  <= trap_d;
      cause_q <= cause_d;
      tpc_q   <= tpc_d;
      ret_q   <= ret_d;
    end
  end

  assign ctx        = ctx_q;
  assign halted     = (fsm_q != RUN);
  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign trap_pc    = tpc_q;
  assign retired    = ret_q;

endmodule

// File: tb/tb_context_commit.sv
// Directed bench for context_commit with a short watchdog (WDT_LIMIT=8).
module tb_context_commit;
  import context_commit_pkg::*;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             halt_req = 1'b0;
  logic             resume = 1'b0;
  logic [CTX_W-1:0] next_ctx;
  logic [CTX_W-1:0] ctx;
  logic             halted, trap;
  logic [1:0]       trap_cause;
  logic [31:0]      trap_pc;
  logic [31:0]      retired;

  context_t nx, c;
  assign next_ctx = nx;
  assign c        = context_t'(ctx);

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  context_commit #(
    .RESET_PC (32'hbfc0_0000),
    .WDT_LIMIT(8),
    .CNT_W    (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .next_ctx  (next_ctx),
    .ctx       (ctx),
    .halt_req  (halt_req),
    .halted    (halted),
    .resume    (resume),
    .trap      (trap),
    .trap_cause(trap_cause),
    .trap_pc   (trap_pc),
    .retired   (retired)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_nx(input cpu_state_t s, input logic [31:0] pc, input logic [31:0] d);
    nx.state = s;
    nx.pc    = pc;
    nx.data  = d;
  endtask

  task automatic do_reset;
    reset = 1'b1; halt_req = 1'b0; resume = 1'b0;
    tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    set_nx(S_FETCH, 32'h100, 32'h0);
    do_reset;
    checks++;
    if (c.state !== S_FETCH || c.pc !== 32'hbfc00000 || c.data !== 32'h0) begin
      errors++; $display("FAIL reset_ctx: got state=%0d pc=%h data=%h want state=0 pc=bfc00000 data=0", c.state, c.pc, c.data);
    end
    checks++;
    if (halted !== 1'b0 || trap !== 1'b0 || trap_cause !== 2'd0 || trap_pc !== 32'h0 || retired !== 32'h0) begin
      errors++; $display("FAIL reset_flags: got halted=%b trap=%b cause=%0d tpc=%h ret=%0d want all 0", halted, trap, trap_cause, trap_pc, retired);
    end
    tick;
    checks++;
    if (c.pc !== 32'h100 || halted !== 1'b0 || retired !== 32'h0) begin
      errors++; $display("FAIL first_commit: got pc=%h halted=%b ret=%0d want pc=100 halted=0 ret=0", c.pc, halted, retired);
    end
  endtask

  task automatic test_retire;
    do_reset;
    for (int i = 0; i < 3; i++) begin
      set_nx(S_DECODE, 32'(32'h10 + i * 16), 32'h0); tick;
      set_nx(S_EXEC,   32'(32'h14 + i * 16), 32'h0); tick;
      set_nx(S_FETCH,  32'(32'h18 + i * 16), 32'h0); tick;
      checks++;
      if (retired !== 32'(i + 1)) begin
        errors++; $display("FAIL retire_loop%0d: got %0d want %0d", i, retired, i + 1);
      end
    end
    set_nx(S_FETCH, 32'h50, 32'h0); tick; tick;
    checks++;
    if (retired !== 32'd3 || c.state !== S_FETCH) begin
      errors++; $display("FAIL retire_fetch_hold: got ret=%0d state=%0d want ret=3 state=0", retired, c.state);
    end
  endtask

  task automatic test_unknown;
    do_reset;
    set_nx(S_FETCH, 32'h2c, 32'h0); tick;
    checks++;
    if (c.pc !== 32'h2c) begin
      errors++; $display("FAIL unk_setup: got pc=%h want 2c", c.pc);
    end
    set_nx(S_UNKNOWN, 32'h30, 32'h55); tick;
    checks++;
    if (c.state !== S_UNKNOWN || c.pc !== 32'h30) begin
      errors++; $display("FAIL unk_commit: got state=%0d pc=%h want state=15 pc=30", c.state, c.pc);
    end
    checks++;
    if (trap !== 1'b1 || trap_cause !== 2'd1 || trap_pc !== 32'h2c || halted !== 1'b1) begin
      errors++; $display("FAIL unk_trap: got trap=%b cause=%0d tpc=%h halted=%b want 1 1 2c 1", trap, trap_cause, trap_pc, halted);
    end
    set_nx(S_DECODE, 32'h44, 32'h0); halt_req = 1'b1; tick;
    checks++;
    if (c.state !== S_UNKNOWN || c.pc !== 32'h30 || halted !== 1'b1) begin
      errors++; $display("FAIL unk_hold: got state=%0d pc=%h halted=%b want 15 30 1", c.state, c.pc, halted);
    end
    halt_req = 1'b0; resume = 1'b1; tick; resume = 1'b0;
    checks++;
    if (c.state !== S_FETCH || c.pc !== 32'hbfc00000 || c.data !== 32'h55) begin
      errors++; $display("FAIL unk_resume_ctx: got state=%0d pc=%h data=%h want 0 bfc00000 55", c.state, c.pc, c.data);
    end
    checks++;
    if (trap !== 1'b0 || trap_cause !== 2'd0 || trap_pc !== 32'h2c || halted !== 1'b0 || retired !== 32'h0) begin
      errors++; $display("FAIL unk_resume_flags: got trap=%b cause=%0d tpc=%h halted=%b ret=%0d want 0 0 2c 0 0", trap, trap_cause, trap_pc, halted, retired);
    end
  endtask

  task automatic test_watchdog;
    do_reset;
    for (int k = 1; k <= 7; k++) begin
      set_nx(S_FETCH, 32'(32'h200 + k), 32'(k)); tick;
    end
    checks++;
    if (trap !== 1'b0 || c.pc !== 32'h207) begin
      errors++; $display("FAIL wdt_before: got trap=%b pc=%h want 0 207", trap, c.pc);
    end
    set_nx(S_FETCH, 32'h208, 32'h8); tick;
    checks++;
    if (trap !== 1'b1 || trap_cause !== 2'd2 || trap_pc !== 32'h207 || halted !== 1'b1) begin
      errors++; $display("FAIL wdt_fire: got trap=%b cause=%0d tpc=%h halted=%b want 1 2 207 1", trap, trap_cause, trap_pc, halted);
    end
    checks++;
    if (c.state !== S_UNKNOWN || c.pc !== 32'h207 || c.data !== 32'h7) begin
      errors++; $display("FAIL wdt_ctx: got state=%0d pc=%h data=%h want 15 207 7", c.state, c.pc, c.data);
    end
    resume = 1'b1; tick; resume = 1'b0;
    checks++;
    if (trap !== 1'b0 || c.state !== S_FETCH) begin
      errors++; $display("FAIL wdt_resume: got trap=%b state=%0d want 0 0", trap, c.state);
    end
    for (int k = 1; k <= 6; k++) begin
      set_nx(S_FETCH, 32'(32'h300 + k), 32'h0); tick;
    end
    set_nx(S_DECODE, 32'h310, 32'h0); tick;
    for (int k = 1; k <= 7; k++) begin
      set_nx(S_DECODE, 32'(32'h310 + k), 32'h0); tick;
    end
    checks++;
    if (trap !== 1'b0 || c.state !== S_DECODE || c.pc !== 32'h317) begin
      errors++; $display("FAIL wdt_restart: got trap=%b state=%0d pc=%h want 0 1 317", trap, c.state, c.pc);
    end
    set_nx(S_DECODE, 32'h318, 32'h0); tick;
    checks++;
    if (trap !== 1'b1 || trap_cause !== 2'd2 || trap_pc !== 32'h317) begin
      errors++; $display("FAIL wdt_refire: got trap=%b cause=%0d tpc=%h want 1 2 317", trap, trap_cause, trap_pc);
    end
  endtask

  task automatic test_halt;
    do_reset;
    resume = 1'b1; set_nx(S_DECODE, 32'h300, 32'h0); tick; resume = 1'b0;
    checks++;
    if (c.pc !== 32'h300 || halted !== 1'b0) begin
      errors++; $display("FAIL run_resume_ignored: got pc=%h halted=%b want 300 0", c.pc, halted);
    end
    halt_req = 1'b1; set_nx(S_EXEC, 32'h304, 32'h0); tick;
    checks++;
    if (c.pc !== 32'h304 || halted !== 1'b1) begin
      errors++; $display("FAIL halt_edge_commit: got pc=%h halted=%b want 304 1", c.pc, halted);
    end
    for (int i = 0; i < 4; i++) begin
      set_nx(S_MEM, 32'(32'h310 + i * 4), 32'h0); tick;
      checks++;
      if (c.pc !== 32'h304 || c.state !== S_EXEC || halted !== 1'b1) begin
        errors++; $display("FAIL halt_frozen%0d: got pc=%h state=%0d halted=%b want 304 2 1", i, c.pc, c.state, halted);
      end
    end
    halt_req = 1'b0; resume = 1'b1; set_nx(S_FETCH, 32'h400, 32'h0); tick; resume = 1'b0;
    checks++;
    if (c.pc !== 32'h304 || halted !== 1'b0) begin
      errors++; $display("FAIL halt_resume: got pc=%h halted=%b want 304 0", c.pc, halted);
    end
    set_nx(S_FETCH, 32'h404, 32'h0); tick;
    checks++;
    if (c.pc !== 32'h404 || retired !== 32'd1) begin
      errors++; $display("FAIL halt_after_resume: got pc=%h ret=%0d want 404 1", c.pc, retired);
    end
    halt_req = 1'b1; set_nx(S_WB, 32'h500, 32'h0); tick;
    resume = 1'b1; set_nx(S_WB, 32'h504, 32'h0); tick; resume = 1'b0;
    checks++;
    if (c.pc !== 32'h500 || halted !== 1'b0) begin
      errors++; $display("FAIL level_resume: got pc=%h halted=%b want 500 0", c.pc, halted);
    end
    tick;
    checks++;
    if (c.pc !== 32'h504 || halted !== 1'b1) begin
      errors++; $display("FAIL level_rehalt: got pc=%h halted=%b want 504 1", c.pc, halted);
    end
    resume = 1'b1; tick; resume = 1'b0;
    set_nx(S_UNKNOWN, 32'h600, 32'h0); tick;
    checks++;
    if (trap !== 1'b1 || trap_cause !== 2'd1 || trap_pc !== 32'h504 || halted !== 1'b1) begin
      errors++; $display("FAIL trap_beats_halt: got trap=%b cause=%0d tpc=%h halted=%b want 1 1 504 1", trap, trap_cause, trap_pc, halted);
    end
    halt_req = 1'b0; resume = 1'b1; tick; resume = 1'b0;
    checks++;
    if (trap !== 1'b0 || halted !== 1'b0 || c.state !== S_FETCH || c.pc !== 32'hbfc00000) begin
      errors++; $display("FAIL trap_clear: got trap=%b halted=%b state=%0d pc=%h want 0 0 0 bfc00000", trap, halted, c.state, c.pc);
    end
  endtask

  task automatic test_reset_trapped;
    set_nx(S_UNKNOWN, 32'h700, 32'h9); tick;
    checks++;
    if (trap !== 1'b1) begin
      errors++; $display("FAIL rt_setup: got trap=%b want 1", trap);
    end
    do_reset;
    checks++;
    if (c.state !== S_FETCH || c.pc !== 32'hbfc00000 || c.data !== 32'h0) begin
      errors++; $display("FAIL rt_ctx: got state=%0d pc=%h data=%h want 0 bfc00000 0", c.state, c.pc, c.data);
    end
    checks++;
    if (halted !== 1'b0 || trap !== 1'b0 || trap_cause !== 2'd0 || trap_pc !== 32'h0 || retired !== 32'h0) begin
      errors++; $display("FAIL rt_flags: got halted=%b trap=%b cause=%0d tpc=%h ret=%0d want all 0", halted, trap, trap_cause, trap_pc, retired);
    end
  endtask

  initial begin
    nx = '0;
    test_reset;
    test_retire;
    test_unknown;
    test_watchdog;
    test_halt;
    test_reset_trapped;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
